// File: rtl/dmem_port_responder.sv
// Bridges L1 data-cache requests onto a 64-bit doubleword memory port. Responses come back
// in order, and requests to unbacked addresses are answered with a page-fault response.
module dmem_port_responder #(
  parameter int unsigned P_DEPTH     = 4,
  parameter logic [31:0] P_MEM_LIMIT = 32'h0400_0000,
  parameter logic [13:0] P_MMU_FLAGS = 14'h0000
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iDATA_REQ,
  output logic        oDATA_LOCK,
  input  logic [1:0]  iDATA_ORDER,
  input  logic [3:0]  iDATA_MASK,
  input  logic        iDATA_RW,
  input  logic [13:0] iDATA_TID,
  input  logic [1:0]  iDATA_MMUMOD,
  input  logic [31:0] iDATA_PDT,
  input  logic [31:0] iDATA_ADDR,
  input  logic [31:0] iDATA_DATA,
  output logic        oDATA_VALID,
  output logic        oDATA_PAGEFAULT,
  output logic [27:0] oDATA_MMU_FLAGS,
  output logic [63:0] oDATA_DATA,
  output logic        oMEM_REQ,
  input  logic        iMEM_BUSY,
  output logic        oMEM_RW,
  output logic [28:0] oMEM_ADDR,
  output logic [7:0]  oMEM_BE,
  output logic [63:0] oMEM_DATA,
  input  logic        iMEM_VALID,
  input  logic [63:0] iMEM_DATA
);

  localparam int unsigned PW = $clog2(P_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] L_FULL    = CW'(P_DEPTH);
  localparam logic [CW-1:0] L_CNT_ONE = CW'(1);
  localparam logic [CW-1:0] L_CNT_ZER = CW'(0);
  localparam logic [PW-1:0] L_PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_PF_DRAIN = 2'd1,
    S_PF_RESP  = 2'd2
  } state_t;

  logic          q_rw_r   [P_DEPTH];
  logic          q_pf_r   [P_DEPTH];
  logic [28:0]   q_addr_r [P_DEPTH];
  logic [7:0]    q_be_r   [P_DEPTH];
  logic [63:0]   q_data_r [P_DEPTH];
  logic          o_rw_r   [P_DEPTH];

  logic [PW-1:0] q_wr_ptr_r, q_rd_ptr_r, o_wr_ptr_r, o_rd_ptr_r;
  logic [CW-1:0] q_cnt_r, q_cnt_nxt_s, o_cnt_r, o_cnt_nxt_s;
  state_t        state_r, state_nxt_s;

  logic          rsp_valid_r, rsp_pf_r;
  logic [27:0]   rsp_flags_r;
  logic [63:0]   rsp_data_r;

  logic accept_s, q_empty_s, head_pf_s, mem_req_s, issue_s, pf_pop_s, pop_s, complete_s;
  logic unused_s;

  assign unused_s   = ^{iDATA_ORDER, iDATA_TID, iDATA_MMUMOD, iDATA_PDT};

  assign oDATA_LOCK = (q_cnt_r == L_FULL);
  assign accept_s   = iDATA_REQ & ~oDATA_LOCK;
  assign q_empty_s  = (q_cnt_r == L_CNT_ZER);
  assign head_pf_s  = q_pf_r[q_rd_ptr_r];
  assign mem_req_s  = ~q_empty_s & ~head_pf_s & (state_r == S_RUN) & (o_cnt_r != L_FULL);
  assign issue_s    = mem_req_s & ~iMEM_BUSY;
  assign pf_pop_s   = (state_r == S_PF_RESP);
  assign pop_s      = issue_s | pf_pop_s;
  // Completions with nothing outstanding (e.g. left over from before a reset) are dropped.
  assign complete_s = iMEM_VALID & (o_cnt_r != L_CNT_ZER);

  assign oMEM_REQ        = mem_req_s;
  assign oMEM_RW         = q_rw_r[q_rd_ptr_r];
  assign oMEM_ADDR       = q_addr_r[q_rd_ptr_r];
  assign oMEM_BE         = q_be_r[q_rd_ptr_r];
  assign oMEM_DATA       = q_data_r[q_rd_ptr_r];
  assign oDATA_VALID     = rsp_valid_r;
  assign oDATA_PAGEFAULT = rsp_pf_r;
  assign oDATA_MMU_FLAGS = rsp_flags_r;
  assign oDATA_DATA      = rsp_data_r;

  // Request FIFO and outstanding-rw FIFO storage (contents are qualified by the counters).
  always_ff @(posedge iCLOCK) begin
    if (accept_s) begin
      q_rw_r[q_wr_ptr_r]   <= iDATA_RW;
      q_pf_r[q_wr_ptr_r]   <= (iDATA_ADDR >= P_MEM_LIMIT);
      q_addr_r[q_wr_ptr_r] <= iDATA_ADDR[31:3];
      q_be_r[q_wr_ptr_r]   <= iDATA_ADDR[2] ? {iDATA_MASK, 4'h0} : {4'h0, iDATA_MASK};
      q_data_r[q_wr_ptr_r] <= {iDATA_DATA, iDATA_DATA};
    end
    if (issue_s) begin
      o_rw_r[o_wr_ptr_r] <= q_rw_r[q_rd_ptr_r];
    end
  end

  // Occupancy of the request FIFO and of the outstanding-request window.
  always_comb begin
    q_cnt_nxt_s = q_cnt_r;
    o_cnt_nxt_s = o_cnt_r;
    case ({accept_s, pop_s})
      2'b10:   q_cnt_nxt_s = q_cnt_r + L_CNT_ONE;
      2'b01:   q_cnt_nxt_s = q_cnt_r - L_CNT_ONE;
      default: q_cnt_nxt_s = q_cnt_r;
    endcase
    case ({issue_s, complete_s})
      2'b10:   o_cnt_nxt_s = o_cnt_r + L_CNT_ONE;
      2'b01:   o_cnt_nxt_s = o_cnt_r - L_CNT_ONE;
      default: o_cnt_nxt_s = o_cnt_r;
    endcase
  end

  // Pointer, counter and state registers.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      q_wr_ptr_r <= {PW{1'b0}};
      q_rd_ptr_r <= {PW{1'b0}};
      o_wr_ptr_r <= {PW{1'b0}};
      o_rd_ptr_r <= {PW{1'b0}};
      q_cnt_r    <= L_CNT_ZER;
      o_cnt_r    <= L_CNT_ZER;
      state_r    <= S_RUN;
    end else begin
      q_cnt_r <= q_cnt_nxt_s;
      o_cnt_r <= o_cnt_nxt_s;
      state_r <= state_nxt_s;
      if (accept_s)   q_wr_ptr_r <= q_wr_ptr_r + L_PTR_ONE;
      if (pop_s)      q_rd_ptr_r <= q_rd_ptr_r + L_PTR_ONE;
      if (issue_s)    o_wr_ptr_r <= o_wr_ptr_r + L_PTR_ONE;
      if (complete_s) o_rd_ptr_r <= o_rd_ptr_r + L_PTR_ONE;
    end
  end

  // A faulting head waits for every earlier memory access to respond before its own response.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_RUN: begin
        if (!q_empty_s && head_pf_s) state_nxt_s = S_PF_DRAIN;
        else                         state_nxt_s = S_RUN;
      end
      S_PF_DRAIN: begin
        if (o_cnt_r == L_CNT_ZER) state_nxt_s = S_PF_RESP;
        else                      state_nxt_s = S_PF_DRAIN;
      end
      S_PF_RESP: state_nxt_s = S_RUN;
      default:   state_nxt_s = S_RUN;
    endcase
  end

  // Response register; data and flags hold between responses, the fault flag does not.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rsp_valid_r <= 1'b0;
      rsp_pf_r    <= 1'b0;
      rsp_flags_r <= 28'h0;
      rsp_data_r  <= 64'h0;
    end else if (complete_s) begin
      rsp_valid_r <= 1'b1;
      rsp_pf_r    <= 1'b0;
      rsp_flags_r <= {P_MMU_FLAGS, P_MMU_FLAGS};
      rsp_data_r  <= o_rw_r[o_rd_ptr_r] ? iMEM_DATA : 64'h0;
    end else if (pf_pop_s) begin
      rsp_valid_r <= 1'b1;
      rsp_pf_r    <= 1'b1;
      rsp_flags_r <= 28'h0;
      rsp_data_r  <= 64'h0;
    end else begin
      rsp_valid_r <= 1'b0;
      rsp_pf_r    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_port_responder.sv
// Randomised and directed bench for dmem_port_responder, scored against an in-order
// transaction model of the request FIFO, the memory port and the response stream.
module tb_dmem_port_responder;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] LIMIT = 32'h0400_0000;
  localparam logic [13:0] FLAGS = 14'h2A5A;

  logic iCLOCK, inRESET, iDATA_REQ, oDATA_LOCK, iDATA_RW;
  logic [1:0]  iDATA_ORDER, iDATA_MMUMOD;
  logic [3:0]  iDATA_MASK;
  logic [13:0] iDATA_TID;
  logic [31:0] iDATA_PDT, iDATA_ADDR, iDATA_DATA;
  logic oDATA_VALID, oDATA_PAGEFAULT, oMEM_REQ, iMEM_BUSY, oMEM_RW, iMEM_VALID;
  logic [27:0] oDATA_MMU_FLAGS;
  logic [63:0] oDATA_DATA, oMEM_DATA, iMEM_DATA;
  logic [28:0] oMEM_ADDR;
  logic [7:0]  oMEM_BE;

  dmem_port_responder #(.P_DEPTH(DEPTH), .P_MEM_LIMIT(LIMIT), .P_MMU_FLAGS(FLAGS)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iDATA_REQ(iDATA_REQ), .oDATA_LOCK(oDATA_LOCK),
    .iDATA_ORDER(iDATA_ORDER), .iDATA_MASK(iDATA_MASK), .iDATA_RW(iDATA_RW),
    .iDATA_TID(iDATA_TID), .iDATA_MMUMOD(iDATA_MMUMOD), .iDATA_PDT(iDATA_PDT),
    .iDATA_ADDR(iDATA_ADDR), .iDATA_DATA(iDATA_DATA), .oDATA_VALID(oDATA_VALID),
    .oDATA_PAGEFAULT(oDATA_PAGEFAULT), .oDATA_MMU_FLAGS(oDATA_MMU_FLAGS),
    .oDATA_DATA(oDATA_DATA), .oMEM_REQ(oMEM_REQ), .iMEM_BUSY(iMEM_BUSY), .oMEM_RW(oMEM_RW),
    .oMEM_ADDR(oMEM_ADDR), .oMEM_BE(oMEM_BE), .oMEM_DATA(oMEM_DATA),
    .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA)
  );

  typedef struct {
    logic        rw;
    logic        pf;
    logic [28:0] addr;
    logic [7:0]  be;
    logic [63:0] data;
    int          acc_edge;
  } req_t;

  req_t req_q[$];   // accepted, still queued in the DUT
  req_t mem_q[$];   // issued to memory, not yet completed
  req_t rsp_q[$];   // awaiting a response, in acceptance order
  int n_checks = 0, n_errors = 0, cyc = 0, last_lat = -1, n_rsp = 0, mem_pct = 100;
  bit stray = 1'b0;

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [28:0] a);
    if (a == 29'h20) return 64'h1122_3344_5566_7788;
    return {a, 3'b110, ~a, 3'b011};
  endfunction

  task automatic set_req(input logic rw, input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] d);
    iDATA_REQ = 1'b1; iDATA_RW = rw; iDATA_ADDR = a; iDATA_MASK = m; iDATA_DATA = d;
    iDATA_ORDER = 2'd2; iDATA_TID = 14'($urandom); iDATA_MMUMOD = 2'($urandom);
    iDATA_PDT = $urandom;
  endtask

  // One clock: score responses at negedge, drive memory, then score issue/accept before the edge.
  task automatic cycle();
    req_t r;
    bit cpl;
    @(negedge iCLOCK);
    if (oDATA_VALID) begin
      if (rsp_q.size() == 0) chk("spurious_rsp", oDATA_VALID, 1'b0);
      else begin
        r = rsp_q.pop_front();
        n_rsp++;
        last_lat = cyc + 1 - r.acc_edge;
        chk("rsp_pf", oDATA_PAGEFAULT, r.pf);
        chk("rsp_data", oDATA_DATA, (r.pf || !r.rw) ? 64'h0 : mem_word(r.addr));
        chk("rsp_flags", oDATA_MMU_FLAGS, r.pf ? 28'h0 : {FLAGS, FLAGS});
        if (r.pf) begin
          chk("pf_at_head", (req_q.size() > 0) ? req_q[0].pf : 1'b0, 1'b1);
          if (req_q.size() > 0 && req_q[0].pf) void'(req_q.pop_front());
        end
      end
    end else chk("pf_idle", oDATA_PAGEFAULT, 1'b0);
    chk("lock", oDATA_LOCK, req_q.size() == DEPTH);
    cpl = (mem_q.size() > 0) && ($urandom_range(99) < mem_pct);
    iMEM_VALID = cpl || stray;
    iMEM_DATA  = (cpl && mem_q[0].rw) ? mem_word(mem_q[0].addr) : {$urandom, $urandom};
    #1;
    if (mem_q.size() == DEPTH) chk("mem_req_full", oMEM_REQ, 1'b0);
    if (req_q.size() == 0) chk("mem_req_empty", oMEM_REQ, 1'b0);
    if (oMEM_REQ && !iMEM_BUSY) begin
      if (req_q.size() == 0 || req_q[0].pf) chk("issue_unexpected", oMEM_REQ, 1'b0);
      else begin
        r = req_q.pop_front();
        chk("mem_rw", oMEM_RW, r.rw);
        chk("mem_addr", oMEM_ADDR, r.addr);
        chk("mem_be", oMEM_BE, r.be);
        chk("mem_data", oMEM_DATA, r.data);
        mem_q.push_back(r);
      end
    end
    if (cpl) void'(mem_q.pop_front());
    if (iDATA_REQ && !oDATA_LOCK) begin
      r.rw = iDATA_RW; r.pf = (iDATA_ADDR >= LIMIT); r.addr = iDATA_ADDR[31:3];
      r.be = iDATA_ADDR[2] ? {iDATA_MASK, 4'h0} : {4'h0, iDATA_MASK};
      r.data = {iDATA_DATA, iDATA_DATA}; r.acc_edge = cyc + 1;
      req_q.push_back(r);
      rsp_q.push_back(r);
    end
    @(posedge iCLOCK);
    cyc++;
    #1;
  endtask

  task automatic send(input logic rw, input logic [31:0] a, input logic [3:0] m,
                      input logic [31:0] d);
    bit acc = 1'b0;
    set_req(rw, a, m, d);
    for (int g = 0; g < 64 && !acc; g++) begin
      acc = !oDATA_LOCK;
      cycle();
    end
    chk("send_accept", acc, 1'b1);
    iDATA_REQ = 1'b0;
  endtask

  task automatic drain(input int budget);
    iDATA_REQ = 1'b0; iMEM_BUSY = 1'b0; mem_pct = 100;
    for (int i = 0; i < budget && rsp_q.size() > 0; i++) cycle();
    chk("drain_done", rsp_q.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, oDATA_VALID, 1'b0);
    chk({tag, "_pf"}, oDATA_PAGEFAULT, 1'b0);
    chk({tag, "_flags"}, oDATA_MMU_FLAGS, 28'h0);
    chk({tag, "_data"}, oDATA_DATA, 64'h0);
    chk({tag, "_memreq"}, oMEM_REQ, 1'b0);
    chk({tag, "_lock"}, oDATA_LOCK, 1'b0);
  endtask

  initial begin
    int base;
    logic [31:0] a;
    inRESET = 1'b0; iDATA_REQ = 1'b0; iDATA_RW = 1'b0; iDATA_ORDER = 2'd0; iDATA_MASK = 4'h0;
    iDATA_TID = 14'h0; iDATA_MMUMOD = 2'd0; iDATA_PDT = 32'h0; iDATA_ADDR = 32'h0;
    iDATA_DATA = 32'h0; iMEM_BUSY = 1'b0; iMEM_VALID = 1'b0; iMEM_DATA = 64'h0;
    #2;
    chk_reset_vals("reset");
    repeat (2) @(posedge iCLOCK);
    #1 inRESET = 1'b1;

    // Single read with one-cycle memory latency.
    set_req(1'b1, 32'h0000_0104, 4'hF, 32'h0);
    cycle();
    iDATA_REQ = 1'b0;
    chk("r21_req", oMEM_REQ, 1'b1);
    chk("r21_addr", oMEM_ADDR, 29'h20);
    for (int i = 0; i < 6; i++) cycle();
    chk("r21_latency", last_lat, 3);
    chk("r21_hold", oDATA_DATA, 64'h1122_3344_5566_7788);

    // Masked write into the upper word.
    set_req(1'b0, 32'h0000_0014, 4'h3, 32'hAABB_CCDD);
    cycle();
    iDATA_REQ = 1'b0;
    chk("r22_be", oMEM_BE, 8'h30);
    chk("r22_data", oMEM_DATA, 64'hAABBCCDD_AABBCCDD);
    chk("r22_rw", oMEM_RW, 1'b0);
    drain(20);

    // Back-to-back reads against a busy memory fill the FIFO.
    base = n_rsp;
    iMEM_BUSY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 32'h40 + 32'(i * 8), 4'hF, $urandom);
      iMEM_BUSY = 1'b1;
      chk("r23_lock", oDATA_LOCK, i == 3);
    end
    set_req(1'b1, 32'h60, 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) cycle();
    chk("r23_held", oDATA_LOCK, 1'b1);
    iMEM_BUSY = 1'b0;
    for (int i = 4; i < 8; i++) send(1'b1, 32'h40 + 32'(i * 8), 4'hF, $urandom);
    drain(60);
    chk("r23_count", n_rsp - base, 8);

    // Fault queued behind two outstanding reads.
    base = n_rsp;
    mem_pct = 0;
    send(1'b1, 32'h200, 4'hF, 32'h0);
    send(1'b1, 32'h208, 4'hF, 32'h0);
    send(1'b1, LIMIT, 4'hF, 32'h0);
    send(1'b1, 32'h210, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) cycle();
    chk("r24_blocked", oMEM_REQ, 1'b0);
    chk("r24_no_rsp", n_rsp - base, 0);
    drain(40);
    chk("r24_count", n_rsp - base, 4);

    // Outstanding window full, then completion and issue on the same edge.
    mem_pct = 0;
    for (int i = 0; i < 6; i++) send(1'b1, 32'h300 + 32'(i * 8), 4'hF, $urandom);
    for (int i = 0; i < 2; i++) cycle();
    chk("r25_blocked", oMEM_REQ, 1'b0);
    mem_pct = 100;
    cycle();
    chk("r25_req_next", oMEM_REQ, 1'b1);
    cycle();
    chk("r25_req_stays", oMEM_REQ, 1'b1);
    drain(40);

    // Random traffic, including addresses just either side of the memory limit.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) < 60) begin
        case ($urandom_range(9))
          0:       a = LIMIT;
          1:       a = LIMIT - 32'd4;
          2:       a = LIMIT + ($urandom & 32'h0000_FFFF);
          default: a = $urandom & 32'h0000_0FFF;
        endcase
        set_req(1'($urandom), a, 4'($urandom), $urandom);
      end else iDATA_REQ = 1'b0;
      iMEM_BUSY = ($urandom_range(99) < 30);
      mem_pct = 50;
      cycle();
    end
    drain(200);

    // Reset with three reads outstanding, then stray completions.
    mem_pct = 0;
    for (int i = 0; i < 3; i++) send(1'b1, 32'h500 + 32'(i * 8), 4'hF, 32'h0);
    for (int i = 0; i < 8 && mem_q.size() < 3; i++) cycle();
    chk("r26_outstanding", mem_q.size(), 3);
    #3 inRESET = 1'b0;
    #1 chk_reset_vals("r26_rst");
    req_q.delete(); mem_q.delete(); rsp_q.delete();
    @(posedge iCLOCK);
    #1 inRESET = 1'b1;
    stray = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    stray = 1'b0;
    iMEM_VALID = 1'b0;
    chk_reset_vals("r26_after");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
